alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised, handshaked successor to the 8-bit ALU. Accepts one operation (A, B, opcode) per
//  valid/ready transfer, registers the result, and holds it until consumed. Adds an internal
//  accumulator, carry/zero flags, and an iterative shift-add multiplier (WIDTH cycles).
//  Sits between the instruction-issue logic and the register-file writeback.
// PARAMETERS
//  WIDTH     8   operand/result width in bits; legal range 2..32
//  ACC_INIT  0   accumulator value after reset (WIDTH bits)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operation present on A/B/opcode
//  in_ready   out  1      block can accept an operation (high only in IDLE)
//  A          in   WIDTH  operand A
//  B          in   WIDTH  operand B; shift/rotate amount is B[$clog2(WIDTH)-1:0]
//  opcode     in   4      operation select (map below)
//  out_valid  out  1      ALU_Out/carry/zero valid
//  out_ready  in   1      consumer accepts result
//  ALU_Out    out  WIDTH  result
//  carry      out  1      carry/borrow/overflow flag for the result
//  zero       out  1      ALU_Out == 0
//  acc_out    out  WIDTH  current accumulator value
// BEHAVIOUR
//  Opcodes: 0000 ADD, 0001 SUB, 0010 MUL, 0011 AND, 0100 OR, 0101 XOR, 0110 NOT A, 0111 SHL,
//   1000 SHR (logical), 1001 ROL, 1010 ROR, 1011 ACC_ADD (acc<=acc+A), 1100 ACC_CLR,
//   1101 EQ, 1110 GTH, 1111 LTH. Compares return {WIDTH-1 zeros, result bit}.
//  Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, ALU_Out=0, carry=0, zero=0,
//   acc=ACC_INIT. Applies immediately, aborting any MUL in progress; no result is produced.
//  FSM: IDLE --(in_valid)--> EXEC (single-cycle ops) or MUL; EXEC -> DONE next edge;
//   MUL runs exactly WIDTH iterations, then -> DONE; DONE --(out_ready)--> IDLE.
//  Transfer: accepted on rising edge with in_valid & in_ready; A, B, opcode captured then, and
//   later input changes have no effect. in_valid while in_ready=0 is ignored (not queued).
//  Latency: single-cycle ops out_valid 2 edges after accept; MUL out_valid WIDTH+1 edges after.
//  Output hold: in DONE, ALU_Out/carry/zero are stable until the edge where out_ready=1;
//   out_valid drops on that edge and in_ready rises. No new accept in the same cycle as release.
//  Width rules: ADD carry = bit WIDTH of A+B; SUB carry = borrow (A<B unsigned), result wraps
//   mod 2^WIDTH; MUL ALU_Out = low WIDTH bits of A*B, carry = |high WIDTH bits; ACC_ADD result
//   = new acc, carry = bit WIDTH of acc+A; shifts/rotates by 0 return A; carry=0 for all others.
//  ACC_CLR: acc<=0, ALU_Out=0, zero=1. acc changes only on ACC_ADD/ACC_CLR, at EXEC edge.
//  Compares (EQ/GTH/LTH) unsigned unless ALU_SIGNED_CMP_EN defined.
// CONFIGURATION
//  ALU_SIGNED_CMP_EN defined: GTH/LTH treat A and B as two's-complement signed values.
//  Not defined: GTH/LTH unsigned. EQ, arithmetic and all other ops unaffected either way.
// TESTING (WIDTH=8, out_ready=1 unless stated)
//  1 LTH: A=02,B=19 -> 01; A=0A,B=05 -> 00; A=B=02 -> 00; each out_valid 2 edges after accept.
//  2 MUL: A=10,B=11 -> out_valid 9 edges after accept, ALU_Out=10, carry=1, in_ready=0 until done.
//  3 Backpressure: ADD A=FF,B=01 with out_ready=0 5 cycles -> ALU_Out=00, carry=1, zero=1 held;
//    in_ready=0 and a second in_valid ignored; raise out_ready -> in_ready=1 next cycle.
//  4 Accumulator: ACC_CLR, ACC_ADD A=F0, ACC_ADD A=20 -> ALU_Out 00, F0, 10(carry=1); acc_out=10.
//  5 Reset mid-MUL: drop rst_n 4 cycles into MUL -> out_valid=0, in_ready=1, acc_out=ACC_INIT
//    immediately; no stale result after release.
//  6 Signed cmp: LTH A=80,B=01 -> 01 with ALU_SIGNED_CMP_EN, 00 without.

Source files
------------

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- handshaked, registered ALU with an accumulator and an iterative
// shift-add multiplier.
//
// One operation (A, B, opcode) is taken per valid/ready transfer. The operands
// are captured on the accept edge, the result is computed (one cycle, or WIDTH
// iterations for MUL) and then held on ALU_Out/carry/zero until the consumer
// takes it with out_ready.
//
// Parameters
//   WIDTH     operand/result width, 2..32
//   ACC_INIT  accumulator value after reset
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operation present on A/B/opcode
//   in_ready   block can accept an operation (high only in IDLE)
//   A, B       operands; shift/rotate amount is B[$clog2(WIDTH)-1:0]
//   opcode     operation select
//   out_valid  ALU_Out/carry/zero valid
//   out_ready  consumer accepts the result
//   ALU_Out    result
//   carry      carry/borrow/overflow flag for the result
//   zero       ALU_Out == 0
//   acc_out    current accumulator value
//
// Configuration macro
//   ALU_SIGNED_CMP_EN  when defined, GTH/LTH compare A and B as two's-complement
//                      signed values; otherwise they compare unsigned.
// -----------------------------------------------------------------------------
module alu_seq #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             carry,
  output logic             zero,
  output logic [WIDTH-1:0] acc_out
);

  localparam int SW = $clog2(WIDTH);  // shift-amount width
  localparam int CW = $clog2(WIDTH);  // multiplier iteration counter width

  // FSM encoding
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Opcode map
  localparam logic [3:0] OP_ADD     = 4'h0;
  localparam logic [3:0] OP_SUB     = 4'h1;
  localparam logic [3:0] OP_MUL     = 4'h2;
  localparam logic [3:0] OP_AND     = 4'h3;
  localparam logic [3:0] OP_OR      = 4'h4;
  localparam logic [3:0] OP_XOR     = 4'h5;
  localparam logic [3:0] OP_NOT     = 4'h6;
  localparam logic [3:0] OP_SHL     = 4'h7;
  localparam logic [3:0] OP_SHR     = 4'h8;
  localparam logic [3:0] OP_ROL     = 4'h9;
  localparam logic [3:0] OP_ROR     = 4'hA;
  localparam logic [3:0] OP_ACC_ADD = 4'hB;
  localparam logic [3:0] OP_ACC_CLR = 4'hC;
  localparam logic [3:0] OP_EQ      = 4'hD;
  localparam logic [3:0] OP_GTH     = 4'hE;
  localparam logic [3:0] OP_LTH     = 4'hF;

  logic [1:0]         state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   acc;

  // Multiplier: prod holds {partial sum, remaining multiplier bits}.
  logic [2*WIDTH-1:0] prod;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_next;

  // Single-cycle datapath results
  logic [WIDTH-1:0]   res_d;
  logic               carry_d;
  logic [WIDTH-1:0]   acc_d;
  logic [WIDTH:0]     sum_add;
  logic [WIDTH:0]     sum_acc;
  logic [2*WIDTH-1:0] rol_full;
  logic [2*WIDTH-1:0] ror_full;
  logic [SW-1:0]      sh;
  logic               gt;
  logic               lt;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign acc_out   = acc;

  // One shift-add step: add A into the upper half when the current multiplier
  // bit is set, then shift the whole product right by one. After WIDTH steps
  // prod equals A*B.
  always_comb begin
    mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, a_q} : '0);
    prod_next = {mul_sum, prod[WIDTH-1:1]};
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case leaves a variable unassigned and no latch is inferred.
  always_comb begin
    res_d    = '0;
    carry_d  = 1'b0;
    acc_d    = acc;
    sum_add  = {1'b0, a_q} + {1'b0, b_q};
    sum_acc  = {1'b0, acc} + {1'b0, a_q};
    sh       = b_q[SW-1:0];
    // Rotates come from shifting a doubled copy: the wrapped bits land in
    // the half that is kept. A zero amount returns A unchanged.
    rol_full = {a_q, a_q} << sh;
    ror_full = {a_q, a_q} >> sh;
`ifdef ALU_SIGNED_CMP_EN
    gt       = $signed(a_q) > $signed(b_q);
    lt       = $signed(a_q) < $signed(b_q);
`else
    gt       = a_q > b_q;
    lt       = a_q < b_q;
`endif
    case (op_q)
      OP_ADD: begin
        res_d   = sum_add[WIDTH-1:0];
        carry_d = sum_add[WIDTH];
      end
      OP_SUB: begin
        res_d   = a_q - b_q;
        carry_d = (a_q < b_q);
      end
      OP_AND:  res_d = a_q & b_q;
      OP_OR:   res_d = a_q | b_q;
      OP_XOR:  res_d = a_q ^ b_q;
      OP_NOT:  res_d = ~a_q;
      OP_SHL:  res_d = a_q << sh;
      OP_SHR:  res_d = a_q >> sh;
      OP_ROL:  res_d = rol_full[2*WIDTH-1:WIDTH];
      OP_ROR:  res_d = ror_full[WIDTH-1:0];
      OP_ACC_ADD: begin
        res_d   = sum_acc[WIDTH-1:0];
        carry_d = sum_acc[WIDTH];
        acc_d   = sum_acc[WIDTH-1:0];
      end
      OP_ACC_CLR: begin
        res_d = '0;
        acc_d = '0;
      end
      OP_EQ:   res_d = {{(WIDTH-1){1'b0}}, (a_q == b_q)};
      OP_GTH:  res_d = {{(WIDTH-1){1'b0}}, gt};
      OP_LTH:  res_d = {{(WIDTH-1){1'b0}}, lt};
      default: res_d = '0;  // MUL never executes through this path
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others, matching real flip-flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      acc     <= ACC_INIT;
      prod    <= '0;
      cnt     <= '0;
      ALU_Out <= '0;
      carry   <= 1'b0;
      zero    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q   <= A;
            b_q   <= B;
            op_q  <= opcode;
            prod  <= {{WIDTH{1'b0}}, B};
            cnt   <= '0;
            state <= (opcode == OP_MUL) ? S_MUL : S_EXEC;
          end
        end
        S_EXEC: begin
          ALU_Out <= res_d;
          carry   <= carry_d;
          zero    <= (res_d == '0);
          acc     <= acc_d;
          state   <= S_DONE;
        end
        S_MUL: begin
          prod <= prod_next;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            ALU_Out <= prod_next[WIDTH-1:0];
            carry   <= |prod_next[2*WIDTH-1:WIDTH];
            zero    <= (prod_next[WIDTH-1:0] == '0);
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          // Release only; a new operation is accepted no earlier than the
          // following edge, once in_ready is visible.
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq -- self-checking bench for alu_seq (WIDTH=8, ACC_INIT=0).
// A directed vector table, hand-written backpressure and reset-mid-MUL
// sequences, then randomized operations checked against an arithmetic model.
// Latency is counted in edges with the accept edge as edge 1.
// -----------------------------------------------------------------------------
module tb_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [3:0]   opcode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] ALU_Out;
  logic         carry;
  logic         zero;
  logic [W-1:0] acc_out;

  int checks   = 0;
  int failures = 0;

  longint model_acc = 0;

  alu_seq #(.WIDTH(W), .ACC_INIT('0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALU_Out   (ALU_Out),
    .carry     (carry),
    .zero      (zero),
    .acc_out   (acc_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   op;
    logic [W-1:0] res;
    logic         cy;
    logic         z;
    logic [W-1:0] acc;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [W-1:0] a, b, input logic [3:0] op,
                         input logic [W-1:0] res, input logic cy, z,
                         input logic [W-1:0] acc, input int lat);
    vec_t v;
    v.a = a; v.b = b; v.op = op; v.res = res; v.cy = cy; v.z = z; v.acc = acc; v.lat = lat;
    vecs.push_back(v);
  endtask

  // Reference model straight from the opcode rules, using wide integers.
  function automatic void model(input longint a, b, input int op, inout longint acc,
                                output longint res, output bit cy);
    longint mask = (64'sd1 <<< W) - 1;
    longint half = 64'sd1 <<< (W - 1);
    longint s    = b & ((64'sd1 <<< $clog2(W)) - 1);
    longint sa   = (a >= half) ? a - (64'sd1 <<< W) : a;
    longint sb   = (b >= half) ? b - (64'sd1 <<< W) : b;
    longint t;
    res = 0;
    cy  = 1'b0;
    case (op)
      0:  begin t = a + b; res = t & mask; cy = (t > mask); end
      1:  begin res = (a - b) & mask; cy = (a < b); end
      2:  begin t = a * b; res = t & mask; cy = ((t >> W) != 0); end
      3:  res = a & b;
      4:  res = a | b;
      5:  res = a ^ b;
      6:  res = (~a) & mask;
      7:  res = (a << s) & mask;
      8:  res = a >> s;
      9:  res = (s == 0) ? a : (((a << s) | (a >> (W - s))) & mask);
      10: res = (s == 0) ? a : (((a >> s) | (a << (W - s))) & mask);
      11: begin t = acc + a; res = t & mask; cy = (t > mask); acc = res; end
      12: begin res = 0; acc = 0; end
      13: res = (a == b) ? 1 : 0;
`ifdef ALU_SIGNED_CMP_EN
      14: res = (sa > sb) ? 1 : 0;
      15: res = (sa < sb) ? 1 : 0;
`else
      14: res = (a > b) ? 1 : 0;
      15: res = (a < b) ? 1 : 0;
`endif
      default: res = 0;
    endcase
  endfunction

  // Issue one operation, measure latency, optionally hold it with out_ready=0
  // for `hold` cycles (checking stability), then release it.
  task automatic do_op(input logic [W-1:0] a, b, input logic [3:0] op, input int hold,
                       output logic [W-1:0] res, output logic cy, z, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("in_ready_timeout", in_ready, 1'b1);
    in_valid  = 1'b1;
    A         = a;
    B         = b;
    opcode    = op;
    out_ready = (hold == 0);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    // Operands must already be captured; scramble the bus.
    in_valid = 1'b0;
    A        = W'($urandom);
    B        = W'($urandom);
    opcode   = 4'($urandom);
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!out_valid) check("out_valid_timeout", out_valid, 1'b1);
    res = ALU_Out;
    cy  = carry;
    z   = zero;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", out_valid, 1'b1);
      check("hold_res", {ALU_Out, carry, zero}, {res, cy, z});
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("release", {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    logic [W-1:0] r;
    logic         c;
    logic         zz;
    int           lat;
    int           seen;
    longint       e_res;
    bit           e_cy;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [3:0]   rop;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    A         = '0;
    B         = '0;
    opcode    = '0;
    out_ready = 1'b1;

    // Directed table (expected values worked out by hand)
    add_vec(8'h02, 8'h19, 4'hF, 8'h01, 0, 0, 8'h00, 2);
    add_vec(8'h0A, 8'h05, 4'hF, 8'h00, 0, 1, 8'h00, 2);
    add_vec(8'h02, 8'h02, 4'hF, 8'h00, 0, 1, 8'h00, 2);
    add_vec(8'h10, 8'h11, 4'h2, 8'h10, 1, 0, 8'h00, W + 1);
    add_vec(8'hFF, 8'hFF, 4'h2, 8'h01, 1, 0, 8'h00, W + 1);
    add_vec(8'h00, 8'h37, 4'h2, 8'h00, 0, 1, 8'h00, W + 1);
    add_vec(8'hFF, 8'h01, 4'h0, 8'h00, 1, 1, 8'h00, 2);
    add_vec(8'h03, 8'h05, 4'h1, 8'hFE, 1, 0, 8'h00, 2);
    add_vec(8'h05, 8'h03, 4'h1, 8'h02, 0, 0, 8'h00, 2);
    add_vec(8'hF0, 8'h3C, 4'h3, 8'h30, 0, 0, 8'h00, 2);
    add_vec(8'hF0, 8'h0F, 4'h4, 8'hFF, 0, 0, 8'h00, 2);
    add_vec(8'hFF, 8'h0F, 4'h5, 8'hF0, 0, 0, 8'h00, 2);
    add_vec(8'h0F, 8'h00, 4'h6, 8'hF0, 0, 0, 8'h00, 2);
    add_vec(8'h81, 8'h01, 4'h7, 8'h02, 0, 0, 8'h00, 2);
    add_vec(8'h81, 8'h03, 4'h8, 8'h10, 0, 0, 8'h00, 2);
    add_vec(8'h5A, 8'h00, 4'h7, 8'h5A, 0, 0, 8'h00, 2);
    add_vec(8'h81, 8'h01, 4'h9, 8'h03, 0, 0, 8'h00, 2);
    add_vec(8'h01, 8'h01, 4'hA, 8'h80, 0, 0, 8'h00, 2);
    add_vec(8'h5A, 8'h08, 4'hA, 8'h5A, 0, 0, 8'h00, 2);
    add_vec(8'h33, 8'h33, 4'hD, 8'h01, 0, 0, 8'h00, 2);
`ifdef ALU_SIGNED_CMP_EN
    add_vec(8'h80, 8'h01, 4'hF, 8'h01, 0, 0, 8'h00, 2);
    add_vec(8'h80, 8'h01, 4'hE, 8'h00, 0, 1, 8'h00, 2);
`else
    add_vec(8'h80, 8'h01, 4'hF, 8'h00, 0, 1, 8'h00, 2);
    add_vec(8'h80, 8'h01, 4'hE, 8'h01, 0, 0, 8'h00, 2);
`endif
    add_vec(8'h00, 8'h00, 4'hC, 8'h00, 0, 1, 8'h00, 2);
    add_vec(8'hF0, 8'h00, 4'hB, 8'hF0, 0, 0, 8'hF0, 2);
    add_vec(8'h20, 8'h00, 4'hB, 8'h10, 1, 0, 8'h10, 2);

    // Reset state
    #12;
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_outputs", {ALU_Out, carry, zero}, '0);
    check("reset_acc", acc_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors
    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].op, 0, r, c, zz, lat);
      check($sformatf("vec%0d_res", i), r, vecs[i].res);
      check($sformatf("vec%0d_carry", i), c, vecs[i].cy);
      check($sformatf("vec%0d_zero", i), zz, vecs[i].z);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_acc", i), acc_out, vecs[i].acc);
    end
    model_acc = 64'h10;

    // Backpressure: ADD FF+01 held 5 cycles, a second request ignored
    do_op_hold_start: begin
      @(negedge clk);
      in_valid = 1'b1; A = 8'hFF; B = 8'h01; opcode = 4'h0; out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("bp_valid", out_valid, 1'b1);
      // Second request stays asserted through the hold and the release edge.
      in_valid = 1'b1; A = 8'h0F; B = 8'h0F; opcode = 4'h3;
      for (int i = 0; i < 5; i++) begin
        @(posedge clk);
        @(negedge clk);
        check("bp_hold", {out_valid, in_ready, ALU_Out, carry, zero}, {1'b1, 1'b0, 8'h00, 1'b1, 1'b1});
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_release", {out_valid, in_ready}, 2'b01);
      in_valid = 1'b0;
    end

    // Reset in the middle of a MUL, with a non-reset accumulator value
    @(negedge clk);
    in_valid = 1'b1; A = 8'h10; B = 8'h11; opcode = 4'h2;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mulrst_busy", in_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mulrst_now", {out_valid, in_ready, acc_out}, {1'b0, 1'b1, 8'h00});
    @(negedge clk);
    rst_n = 1'b1;
    model_acc = 0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("mulrst_no_stale", seen, 0);
    check("mulrst_out", {ALU_Out, carry, zero}, '0);

    // Randomized operations against the model
    for (int i = 0; i < 150; i++) begin
      ra  = W'($urandom);
      rb  = W'($urandom);
      rop = 4'($urandom_range(0, 15));
      model(longint'(ra), longint'(rb), int'(rop), model_acc, e_res, e_cy);
      do_op(ra, rb, rop, $urandom_range(0, 2), r, c, zz, lat);
      check($sformatf("rnd%0d_op%0h_res", i, rop), r, e_res);
      check($sformatf("rnd%0d_op%0h_carry", i, rop), c, e_cy);
      check($sformatf("rnd%0d_op%0h_zero", i, rop), zz, (e_res == 0));
      check($sformatf("rnd%0d_op%0h_latency", i, rop), lat, (rop == 4'h2) ? W + 1 : 2);
      check($sformatf("rnd%0d_acc", i), acc_out, model_acc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
